// File: rtl/axis_hdr_pkg.sv
// Shared state encoding and byte-count helpers for the AXI-Stream header inserter.
// Helpers work on MAX_BYTES-wide lane vectors; callers zero-extend and slice.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int MAX_BYTES = 128;

  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c = c + (v[i] ? 1 : 0);
    end
    return c;
  endfunction

  // cnt ones packed against bit width-1 of a width-bit lane vector
  function automatic logic [MAX_BYTES-1:0] left_mask(input int cnt, input int width);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < width && i >= width - cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_BYTES-1:0] right_mask(input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Byte-merge datapath: residue bytes followed by the top bytes of the input beat.
// Purely combinational; the top module owns all state.
module axis_byte_merge #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = 3
) (
  input  logic [DATA_WD-1:0] residue,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [CNT_WD-1:0]  n_bytes,
  output logic [DATA_WD-1:0] merged,
  output logic [DATA_WD-1:0] next_residue,
  output logic [DATA_WD-1:0] flush_data
);

  logic [DATA_WD-1:0] low_mask;
  int                 lo_sh;
  int                 hi_sh;

  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_lane
    assign low_mask[8*gi +: 8] = (gi < int'(n_bytes)) ? 8'hFF : 8'h00;
  end

  assign lo_sh = 8 * int'(n_bytes);
  assign hi_sh = 8 * (DATA_BYTE_WD - int'(n_bytes));

  // The residue occupies the low n_bytes lanes, so shifting it up lands it at the MSB end
  assign merged       = (residue << hi_sh) | (data_in >> lo_sh);
  assign next_residue = data_in & low_mask;
  assign flush_data   = residue << hi_sh;

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends an N-byte header to each AXI-Stream packet; FSM and handshaking live here.
// Define AXIS_INSERT_HDR_CHECK_EN to compile in protocol assertions.
module axi_stream_insert_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int NW = BYTE_CNT_WD + 1;

  state_t                  state_reg, state_next;
  logic [DATA_WD-1:0]      residue_reg, residue_next;
  logic [NW-1:0]           n_reg, n_next;
  logic [NW-1:0]           flush_cnt_reg, flush_cnt_next;
  logic                    valid_out_reg, valid_out_next;
  logic [DATA_WD-1:0]      data_out_reg, data_out_next;
  logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
  logic                    last_out_reg, last_out_next;

  logic [DATA_WD-1:0]      merged, merged_residue, flush_data, hdr_bytes;
  logic [MAX_BYTES-1:0]    keep_in_ext, last_mask_full, flush_mask_full;
  logic                    out_free, in_fire, hdr_fire;
  int                      n_hdr, k_last, room;
  logic                    unused_sig;

  assign out_free     = !valid_out_reg || ready_out;
  assign ready_insert = !rst && (state_reg == ST_HDR);
  assign ready_in     = !rst && (state_reg == ST_DATA) && out_free;
  assign hdr_fire     = valid_insert && ready_insert;
  assign in_fire      = valid_in && ready_in;

  assign n_hdr           = (byte_insert_cnt == '0) ? DATA_BYTE_WD : int'(byte_insert_cnt);
  assign keep_in_ext     = MAX_BYTES'(keep_in);
  assign k_last          = popcount(keep_in_ext);
  assign room            = DATA_BYTE_WD - int'(n_reg);
  assign last_mask_full  = left_mask(int'(n_reg) + k_last, DATA_BYTE_WD);
  assign flush_mask_full = left_mask(int'(flush_cnt_reg), DATA_BYTE_WD);

  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_hdr_lane
    assign hdr_bytes[8*gi +: 8] = (gi < n_hdr) ? data_insert[8*gi +: 8] : 8'h00;
  end

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_WD       (NW)
  ) u_merge (
    .residue      (residue_reg),
    .data_in      (data_in),
    .n_bytes      (n_reg),
    .merged       (merged),
    .next_residue (merged_residue),
    .flush_data   (flush_data)
  );

  always_comb begin
    state_next     = state_reg;
    residue_next   = residue_reg;
    n_next         = n_reg;
    flush_cnt_next = flush_cnt_reg;
    valid_out_next = valid_out_reg;
    data_out_next  = data_out_reg;
    keep_out_next  = keep_out_reg;
    last_out_next  = last_out_reg;
    if (valid_out_reg && ready_out) valid_out_next = 1'b0;

    unique case (state_reg)
      ST_HDR: begin
        if (hdr_fire) begin
          residue_next = hdr_bytes;
          n_next       = NW'(n_hdr);
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (in_fire) begin
          valid_out_next = 1'b1;
          data_out_next  = merged;
          residue_next   = merged_residue;
          keep_out_next  = '1;
          last_out_next  = 1'b0;
          if (last_in) begin
            if (k_last <= room) begin
              keep_out_next = last_mask_full[DATA_BYTE_WD-1:0];
              last_out_next = 1'b1;
              state_next    = ST_HDR;
            end else begin
              // Tail bytes spill into one extra beat drawn from the new residue
              flush_cnt_next = NW'(k_last - room);
              state_next     = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          valid_out_next = 1'b1;
          data_out_next  = flush_data;
          keep_out_next  = flush_mask_full[DATA_BYTE_WD-1:0];
          last_out_next  = 1'b1;
          state_next     = ST_HDR;
        end
      end
      default: state_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HDR;
      residue_reg   <= '0;
      n_reg         <= '0;
      flush_cnt_reg <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      last_out_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      residue_reg   <= residue_next;
      n_reg         <= n_next;
      flush_cnt_reg <= flush_cnt_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      keep_out_reg  <= keep_out_next;
      last_out_reg  <= last_out_next;
    end
  end

  assign valid_out = valid_out_reg && !rst;
  assign last_out  = last_out_reg && !rst;
  assign keep_out  = rst ? '0 : keep_out_reg;
  assign data_out  = rst ? '0 : data_out_reg;

  // keep_insert is advisory only; the header length comes from byte_insert_cnt
  assign unused_sig = ^{keep_insert, last_mask_full[MAX_BYTES-1:DATA_BYTE_WD],
                        flush_mask_full[MAX_BYTES-1:DATA_BYTE_WD]};

`ifdef AXIS_INSERT_HDR_CHECK_EN
  logic [MAX_BYTES-1:0] keep_insert_ext;
  assign keep_insert_ext = MAX_BYTES'(keep_insert);

  a_keep_insert: assert property (@(posedge clk) disable iff (rst)
    valid_insert |-> (keep_insert_ext == right_mask(n_hdr)));
  a_keep_last: assert property (@(posedge clk) disable iff (rst)
    (valid_in && last_in) |-> (k_last != 0 && keep_in_ext == left_mask(k_last, DATA_BYTE_WD)));
  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (valid_in && !ready_in) |=> valid_in);
  a_data_hold: assert property (@(posedge clk) disable iff (rst)
    (valid_in && !ready_in) |=> $stable(data_in));
`endif

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Randomized bench: each packet is flattened to a byte list (header + payload) and
// re-chunked into expected output beats, which a monitor compares against the DUT.
module tb_axi_stream_insert_header;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in;
  logic [BW-1:0] keep_in;
  logic          valid_out, last_out, ready_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          valid_insert, ready_insert;
  logic [DW-1:0] data_insert;
  logic [BW-1:0] keep_insert;
  logic [CW-1:0] byte_insert_cnt;

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [BW-1:0] k);
    logic [DW-1:0] m;
    for (int j = 0; j < BW; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  // Downstream ready: always 1 in directed phases, random otherwise
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare plus hold-while-stalled check
  initial begin
    beat_t       e;
    logic        prev_stall;
    logic [37:0] prev_snap;
    prev_stall = 1'b0;
    prev_snap  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'(prev_snap));
        if (valid_out && ready_out) begin
          $display("[%0t] out data=%h keep=%b last=%b", $time, data_out, keep_out, last_out);
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("keep_out", 64'(keep_out), 64'(e.keep));
            check("last_out", 64'(last_out), 64'(e.last));
            check("data_out", 64'(data_out & lane_mask(e.keep)), 64'(e.data & lane_mask(e.keep)));
          end
        end
        prev_stall = valid_out && !ready_out;
        prev_snap  = {valid_out, last_out, keep_out, data_out};
      end
    end
  end

  task automatic wait_hs(input string tag, input bit is_hdr);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (is_hdr ? ready_insert : ready_in) break;
      t++;
      if (t > 2000) begin
        check({tag, "_timeout"}, 64'(0), 64'(1));
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // cnt_field: raw byte_insert_cnt; nb beats; k bytes on last beat
  task automatic send_packet(input int cnt_field, input int nb, input int k,
                             input logic [DW-1:0] hdr, input bit pattern,
                             input bit early, input int abort_after, input bit gaps);
    int            n;
    logic [7:0]    bq[$];
    logic [DW-1:0] beats[$];
    logic [BW-1:0] kl;
    n  = (cnt_field == 0) ? BW : cnt_field;
    kl = '0;
    for (int j = 0; j < k; j++) kl[BW-1-j] = 1'b1;
    for (int b = 0; b < nb; b++)
      beats.push_back(pattern ? 32'h10203040 + 32'(b) * 32'h01010101 : $urandom);
    for (int i = n - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    for (int b = 0; b < nb; b++) begin
      int c;
      c = (b == nb - 1) ? k : BW;
      for (int j = BW - 1; j >= BW - c; j--) bq.push_back(beats[b][8*j +: 8]);
    end
    for (int s = 0; s < bq.size(); s += BW) begin
      beat_t e;
      int    c;
      c = (bq.size() - s < BW) ? bq.size() - s : BW;
      e.data = '0;
      e.keep = '0;
      for (int t = 0; t < c; t++) begin
        e.data[8*(BW-1-t) +: 8] = bq[s+t];
        e.keep[BW-1-t] = 1'b1;
      end
      e.last = (s + BW >= bq.size());
      exp_q.push_back(e);
    end
    $display("[%0t] packet N=%0d beats=%0d k=%0d hdr=%h", $time, n, nb, k, hdr);

    if (early) begin
      valid_in = 1'b1;
      data_in  = beats[0];
      last_in  = (nb == 1);
      keep_in  = (nb == 1) ? kl : 4'($urandom);
      repeat (5) begin
        @(negedge clk);
        check("ready_in_no_hdr", 64'(ready_in), 64'(0));
      end
      @(posedge clk);
      #1;
    end

    valid_insert    = 1'b1;
    data_insert     = hdr;
    byte_insert_cnt = CW'(cnt_field);
    keep_insert     = BW'((1 << n) - 1);
    wait_hs("hdr", 1'b1);
    valid_insert = 1'b0;
    data_insert  = $urandom;

    for (int b = 0; b < nb; b++) begin
      if (!(early && b == 0)) begin
        if (gaps) begin
          valid_in = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        valid_in = 1'b1;
        data_in  = beats[b];
        last_in  = (b == nb - 1);
        keep_in  = (b == nb - 1) ? kl : 4'($urandom);
      end
      wait_hs("beat", 1'b0);
      valid_in = 1'b0;
      last_in  = 1'b0;
      if (abort_after > 0 && b == abort_after) return;
    end
    @(negedge clk);
    check("ready_in_after_last", 64'(ready_in), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_last_out", 64'(last_out), 64'(0));
    check("rst_keep_out", 64'(keep_out), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_ready_in", 64'(ready_in), 64'(0));
    check("rst_ready_insert", 64'(ready_insert), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_insert", 64'(ready_insert), 64'(1));
    check("post_rst_valid_out", 64'(valid_out), 64'(0));
    @(posedge clk);
    #1;

    // Directed: N=3, last keep 1000 / 1100; N=4 with two full beats
    send_packet(3, 8, 1, 32'h00555555, 1'b1, 1'b0, 0, 1'b0);
    drain();
    send_packet(3, 8, 2, 32'h00555555, 1'b1, 1'b0, 0, 1'b0);
    drain();
    send_packet(0, 2, 4, 32'h00555555, 1'b1, 1'b0, 0, 1'b0);
    drain();
    // Data presented before any header must stall
    send_packet(2, 3, 3, $urandom, 1'b0, 1'b1, 0, 1'b0);
    drain();

    // Random backpressure and input gaps, then back-to-back random packets
    rand_ready = 1'b1;
    send_packet(3, 8, 1, 32'h00555555, 1'b1, 1'b0, 0, 1'b1);
    drain();
    repeat (40)
      send_packet($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 4),
                  $urandom, 1'b0, 1'b0, 0, 1'($urandom_range(0, 1)));
    drain();

    // Reset in the middle of a packet
    send_packet(1, 6, 3, $urandom, 1'b0, 1'b0, 3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid_out", 64'(valid_out), 64'(0));
    check("abort_ready_insert", 64'(ready_insert), 64'(1));
    @(posedge clk);
    #1;
    send_packet(2, 3, 4, $urandom, 1'b0, 1'b0, 0, 1'b1);
    drain();

    finish_run();
  end

endmodule
